// File: rtl/beat_link_pkg.sv
// Shared constants, FSM encodings and the packet checksum helper for beat_link.
package beat_link_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] BCAST_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        R_SYNC = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_CHK  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_LATCH = 2'd1,
        T_BUSY  = 2'd2,
        T_DONE  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] pkt_chk(input logic [7:0] addr, input logic [7:0] data);
        return addr ^ data ^ SYNC_BYTE;
    endfunction

endpackage

// File: rtl/beat_link_tx.sv
// Transmit scheduler: saturating ACK/status pending flags, ACK-first arbiter and
// latch/done handshake towards the byte-level UART transmitter.
module beat_link_tx
    import beat_link_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ack_req_i,
    input  logic       stat_req_i,
    input  logic [7:0] sw_i,
    input  logic       tx_done_i,
    output logic       tx_latch_o,
    output logic [7:0] tx_data_o
);

    tx_state_t  state_q, state_d;
    logic       ack_pend_q, ack_pend_d;
    logic       stat_pend_q, stat_pend_d;
    logic [7:0] data_q, data_d;
    logic       latch_q, latch_d;
    logic       ack_clr_s, stat_clr_s;

    // Next-state, arbitration and pending-flag update.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ack_clr_s  = 1'b0;
        stat_clr_s = 1'b0;
        case (state_q)
            T_IDLE: begin
                if (tx_done_i && ack_pend_q) begin
                    data_d    = ACK_BYTE;
                    ack_clr_s = 1'b1;
                    state_d   = T_LATCH;
                end else if (tx_done_i && stat_pend_q) begin
                    data_d     = sw_i;
                    stat_clr_s = 1'b1;
                    state_d    = T_LATCH;
                end else begin
                    state_d = T_IDLE;
                end
            end
            T_LATCH: state_d = T_BUSY;
            T_BUSY: begin
                if (!tx_done_i) begin
                    state_d = T_DONE;
                end else begin
                    state_d = T_BUSY;
                end
            end
            T_DONE: begin
                if (tx_done_i) begin
                    state_d = T_IDLE;
                end else begin
                    state_d = T_DONE;
                end
            end
            default: state_d = T_IDLE;
        endcase
        // A new request arriving while its flag is being consumed stays pending.
        ack_pend_d  = (ack_pend_q & ~ack_clr_s) | ack_req_i;
        stat_pend_d = (stat_pend_q & ~stat_clr_s) | stat_req_i;
        latch_d     = (state_d == T_LATCH);
    end

    // State, flag and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= T_IDLE;
            ack_pend_q  <= 1'b0;
            stat_pend_q <= 1'b0;
            data_q      <= 8'h00;
            latch_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_pend_q  <= ack_pend_d;
            stat_pend_q <= stat_pend_d;
            data_q      <= data_d;
            latch_q     <= latch_d;
        end
    end

    assign tx_latch_o = latch_q;
    assign tx_data_o  = data_q;

endmodule

// File: rtl/beat_link.sv
// UART link controller: parses SYNC/ADDR/DATA/CHK packets into channel registers
// and schedules ACK and periodic switch-status bytes onto the transmitter.
module beat_link
    import beat_link_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int CH_W        = 4,
    parameter int STAT_PERIOD = 1000000,
    parameter int TIMEOUT     = 50000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_l,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     tx_done,
    output logic                     tx_latch,
    output logic [7:0]               tx_data,
    input  logic [7:0]               sw,
    output logic [NUM_CH*CH_W-1:0]   ch_out,
    output logic [7:0]               leds,
    output logic                     frame_err
);

    localparam int GW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STAT_PERIOD);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STAT_LAST = SW'(STAT_PERIOD - 1);
    localparam logic [7:0]    NUM_CH_B  = 8'(NUM_CH);

    rx_state_t               rx_state_q, rx_state_d;
    logic [7:0]              addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [SW-1:0]           stat_q, stat_d;
    logic [NUM_CH*CH_W-1:0]  ch_q, ch_d;
    logic [7:0]              leds_q, leds_d;
    logic                    ferr_q, ferr_d;
    logic                    ack_req_s, stat_req_s;

    // Receive parser, commit and inter-byte timeout.
    always_comb begin
        rx_state_d = rx_state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        gap_d      = gap_q;
        ch_d       = ch_q;
        leds_d     = leds_q;
        ferr_d     = 1'b0;
        ack_req_s  = 1'b0;
        if (rx_valid) begin
            gap_d = '0;
            case (rx_state_q)
                R_SYNC: begin
                    if (rx_data == SYNC_BYTE) begin
                        rx_state_d = R_ADDR;
                    end else begin
                        rx_state_d = R_SYNC;
                    end
                end
                R_ADDR: begin
                    addr_d     = rx_data;
                    rx_state_d = R_DATA;
                end
                R_DATA: begin
                    data_d     = rx_data;
                    rx_state_d = R_CHK;
                end
                R_CHK: begin
                    rx_state_d = R_SYNC;
                    if ((rx_data == pkt_chk(addr_q, data_q)) &&
                        ((addr_q < NUM_CH_B) || (addr_q == BCAST_ADDR))) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if ((addr_q == BCAST_ADDR) || (addr_q == 8'(i))) begin
                                ch_d[i*CH_W +: CH_W] = data_q[CH_W-1:0];
                            end else begin
                                ch_d[i*CH_W +: CH_W] = ch_q[i*CH_W +: CH_W];
                            end
                        end
                        leds_d    = data_q;
                        ack_req_s = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: rx_state_d = R_SYNC;
            endcase
        end else if (rx_state_q != R_SYNC) begin
            if (gap_q == GAP_LAST) begin
                gap_d      = '0;
                rx_state_d = R_SYNC;
                ferr_d     = 1'b1;
            end else begin
                gap_d = gap_q + GW'(1'b1);
            end
        end else begin
            gap_d = '0;
        end
    end

    // Free-running status period timer.
    always_comb begin
        if (stat_q == STAT_LAST) begin
            stat_d     = '0;
            stat_req_s = 1'b1;
        end else begin
            stat_d     = stat_q + SW'(1'b1);
            stat_req_s = 1'b0;
        end
    end

    // Receive-side registers.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rx_state_q <= R_SYNC;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            gap_q      <= '0;
            stat_q     <= '0;
            ch_q       <= '0;
            leds_q     <= 8'h00;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            gap_q      <= gap_d;
            stat_q     <= stat_d;
            ch_q       <= ch_d;
            leds_q     <= leds_d;
            ferr_q     <= ferr_d;
        end
    end

    beat_link_tx u_tx (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_l),
        .ack_req_i  (ack_req_s),
        .stat_req_i (stat_req_s),
        .sw_i       (sw),
        .tx_done_i  (tx_done),
        .tx_latch_o (tx_latch),
        .tx_data_o  (tx_data)
    );

    assign ch_out    = ch_q;
    assign leds      = leds_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_beat_link.sv
// Self-checking bench for beat_link: packet-level reference model plus a
// transmitter model that records every latched byte.
module tb_beat_link;

    localparam int NUM_CH      = 3;
    localparam int CH_W        = 4;
    localparam int STAT_PERIOD = 400;
    localparam int TIMEOUT     = 60;

    logic                    sys_clk   = 1'b0;
    logic                    sys_rst_l = 1'b0;
    logic                    rx_valid  = 1'b0;
    logic [7:0]              rx_data   = 8'h00;
    logic                    tx_done   = 1'b1;
    logic                    tx_latch;
    logic [7:0]              tx_data;
    logic [7:0]              sw        = 8'h3C;
    logic [NUM_CH*CH_W-1:0]  ch_out;
    logic [7:0]              leds;
    logic                    frame_err;

    beat_link #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .STAT_PERIOD(STAT_PERIOD), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_done(tx_done), .tx_latch(tx_latch), .tx_data(tx_data), .sw(sw),
        .ch_out(ch_out), .leds(leds), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;
    int busy_len = 20;
    int busy_left = 0;
    int fe_count = 0;
    int viol = 0;
    int cyc = 0;
    logic prev_latch = 1'b0;
    logic prev_fe = 1'b0;
    logic [7:0] cap_q[$];
    int         cap_t[$];

    // reference model state
    logic [7:0] m_ch[NUM_CH];
    logic [7:0] m_leds;
    int exp_ack = 0;
    int exp_fe = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Transmitter model and protocol monitor, active on the falling edge.
    initial begin : tx_model
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_l) begin
                busy_left = 0; tx_done = 1'b1; prev_latch = 1'b0; prev_fe = 1'b0;
            end else begin
                if (frame_err === 1'b1) begin
                    fe_count++;
                    if (prev_fe) viol++;
                end
                prev_fe = frame_err;
                if (tx_latch === 1'b1) begin
                    cap_q.push_back(tx_data);
                    cap_t.push_back(cyc);
                    if (!tx_done || prev_latch) viol++;
                    busy_left = busy_len;
                    tx_done = 1'b0;
                end else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) tx_done = 1'b1;
                end
                prev_latch = tx_latch;
            end
        end
    end

    function automatic logic [NUM_CH*CH_W-1:0] exp_ch();
        logic [NUM_CH*CH_W-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i*CH_W +: CH_W] = m_ch[i][CH_W-1:0];
        return r;
    endfunction

    function automatic void model_packet(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        if ((c == (a ^ d ^ 8'hA5)) && ((a < NUM_CH) || (a == 8'hFF))) begin
            for (int i = 0; i < NUM_CH; i++)
                if (a == 8'hFF || a == i) m_ch[i] = d;
            m_leds = d;
            exp_ack++;
        end else begin
            exp_fe++;
        end
    endfunction

    function automatic int count_byte(input logic [7:0] b, input int from);
        int n = 0;
        for (int i = from; i < cap_q.size(); i++) if (cap_q[i] == b) n++;
        return n;
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int gap);
        drive_byte(b0); if (gap > 0) idle(gap);
        drive_byte(b1); if (gap > 0) idle(gap);
        drive_byte(b2); if (gap > 0) idle(gap);
        drive_byte(b3);
        idle(1);
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst_l = 1'b0;
        rx_valid  = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < NUM_CH; i++) m_ch[i] = 8'h00;
        m_leds = 8'h00;
        cap_q.delete();
        cap_t.delete();
        sys_rst_l = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (ch_out !== '0) begin miscompares++; $display("FAIL reset_ch_out got %h want 0", ch_out); end
        vectors++; if (leds !== 8'h00) begin miscompares++; $display("FAIL reset_leds got %h want 00", leds); end
        vectors++; if (tx_latch !== 1'b0) begin miscompares++; $display("FAIL reset_tx_latch got %b want 0", tx_latch); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    endtask

    task automatic test_single();
        int mark = cap_q.size();
        int fe0  = fe_count;
        send_pkt(8'hA5, 8'h01, 8'h0B, 8'hAF, 0);
        model_packet(8'h01, 8'h0B, 8'hAF);
        vectors++; if (ch_out !== 12'h0B0) begin miscompares++; $display("FAIL single_ch_out got %h want 0b0", ch_out); end
        vectors++; if (leds !== 8'h0B) begin miscompares++; $display("FAIL single_leds got %h want 0b", leds); end
        idle(70);
        vectors++; if (count_byte(8'h06, mark) !== 1) begin miscompares++; $display("FAIL single_ack got %0d want 1", count_byte(8'h06, mark)); end
        vectors++; if (fe_count !== fe0) begin miscompares++; $display("FAIL single_ferr got %0d want %0d", fe_count, fe0); end
    endtask

    task automatic test_broadcast();
        int mark = cap_q.size();
        int fe0  = fe_count;
        send_pkt(8'hA5, 8'hFF, 8'h07, 8'h5D, 0);
        model_packet(8'hFF, 8'h07, 8'h5D);
        vectors++; if (ch_out !== 12'h777) begin miscompares++; $display("FAIL bcast_ch_out got %h want 777", ch_out); end
        idle(70);
        vectors++; if (count_byte(8'h06, mark) !== 1) begin miscompares++; $display("FAIL bcast_ack got %0d want 1", count_byte(8'h06, mark)); end
        vectors++; if (fe_count !== fe0) begin miscompares++; $display("FAIL bcast_ferr got %0d want %0d", fe_count, fe0); end
    endtask

    task automatic test_errors();
        int mark = cap_q.size();
        int fe0  = fe_count;
        send_pkt(8'hA5, 8'h01, 8'h0B, 8'h00, 0);
        model_packet(8'h01, 8'h0B, 8'h00);
        send_pkt(8'hA5, 8'h05, 8'h01, 8'hA1, 1);
        model_packet(8'h05, 8'h01, 8'hA1);
        idle(70);
        vectors++; if (fe_count !== fe0 + 2) begin miscompares++; $display("FAIL err_ferr_count got %0d want %0d", fe_count, fe0 + 2); end
        vectors++; if (ch_out !== exp_ch()) begin miscompares++; $display("FAIL err_ch_out got %h want %h", ch_out, exp_ch()); end
        vectors++; if (count_byte(8'h06, mark) !== 0) begin miscompares++; $display("FAIL err_ack got %0d want 0", count_byte(8'h06, mark)); end
    endtask

    task automatic test_timeout();
        int n = 0;
        int fe0;
        drive_byte(8'hA5);
        drive_byte(8'h02);
        for (int i = 1; i <= 2 * TIMEOUT && n == 0; i++) begin
            @(negedge sys_clk);
            rx_valid = 1'b0;
            if (frame_err === 1'b1) n = i;
        end
        exp_fe++;
        vectors++; if (n !== TIMEOUT + 1) begin miscompares++; $display("FAIL timeout_cycle got %0d want %0d", n, TIMEOUT + 1); end
        idle(3);
        fe0 = fe_count;
        send_pkt(8'hA5, 8'h02, 8'h0C, 8'hAB, 0);
        model_packet(8'h02, 8'h0C, 8'hAB);
        vectors++; if (ch_out !== exp_ch()) begin miscompares++; $display("FAIL timeout_recover got %h want %h", ch_out, exp_ch()); end
        // data byte lands exactly on the would-be timeout cycle
        drive_byte(8'hA5);
        drive_byte(8'h02);
        idle(TIMEOUT - 1);
        drive_byte(8'h09);
        drive_byte(8'hAE);
        idle(1);
        model_packet(8'h02, 8'h09, 8'hAE);
        vectors++; if (ch_out !== exp_ch()) begin miscompares++; $display("FAIL timeout_edge_ch got %h want %h", ch_out, exp_ch()); end
        idle(70);
        vectors++; if (fe_count !== fe0) begin miscompares++; $display("FAIL timeout_edge_ferr got %0d want %0d", fe_count, fe0); end
    endtask

    task automatic test_status();
        int v0;
        apply_reset();
        busy_len = 100;
        sw = 8'h3C;
        v0 = viol;
        repeat (3 * STAT_PERIOD + 20) @(negedge sys_clk);
        vectors++; if (cap_q.size() !== 3) begin miscompares++; $display("FAIL status_count got %0d want 3", cap_q.size()); end
        for (int i = 0; i < cap_q.size(); i++) begin
            vectors++; if (cap_q[i] !== 8'h3C) begin miscompares++; $display("FAIL status_byte%0d got %h want 3c", i, cap_q[i]); end
        end
        for (int i = 1; i < cap_t.size(); i++) begin
            vectors++; if (cap_t[i] - cap_t[i-1] !== STAT_PERIOD) begin miscompares++; $display("FAIL status_period got %0d want %0d", cap_t[i] - cap_t[i-1], STAT_PERIOD); end
        end
        vectors++; if (viol !== v0) begin miscompares++; $display("FAIL status_handshake got %0d want %0d", viol, v0); end
        busy_len = 20;
    endtask

    task automatic test_collision();
        int v0;
        apply_reset();
        v0 = viol;
        repeat (STAT_PERIOD - 4) @(posedge sys_clk);
        send_pkt(8'hA5, 8'h00, 8'h05, 8'hA0, 0);
        model_packet(8'h00, 8'h05, 8'hA0);
        idle(60);
        vectors++; if (cap_q.size() !== 2) begin miscompares++; $display("FAIL coll_count got %0d want 2", cap_q.size()); end
        vectors++; if (cap_q.size() < 1 || cap_q[0] !== 8'h06) begin miscompares++; $display("FAIL coll_first got %h want 06", cap_q.size() > 0 ? cap_q[0] : 8'hXX); end
        vectors++; if (cap_q.size() < 2 || cap_q[1] !== 8'h3C) begin miscompares++; $display("FAIL coll_second got %h want 3c", cap_q.size() > 1 ? cap_q[1] : 8'hXX); end
        vectors++; if (ch_out !== exp_ch()) begin miscompares++; $display("FAIL coll_ch_out got %h want %h", ch_out, exp_ch()); end
        vectors++; if (viol !== v0) begin miscompares++; $display("FAIL coll_handshake got %0d want %0d", viol, v0); end
    endtask

    task automatic test_reset_mid();
        int fe0;
        int seen = 0;
        drive_byte(8'hA5);
        drive_byte(8'h01);
        apply_reset();
        fe0 = fe_count;
        drive_byte(8'h0B);
        drive_byte(8'hAF);
        idle(5);
        vectors++; if (ch_out !== '0) begin miscompares++; $display("FAIL midpkt_ch_out got %h want 0", ch_out); end
        vectors++; if (fe_count !== fe0) begin miscompares++; $display("FAIL midpkt_ferr got %0d want %0d", fe_count, fe0); end
        send_pkt(8'hA5, 8'h01, 8'h03, 8'hA7, 0);
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge sys_clk);
            if (tx_latch === 1'b1) seen = 1;
        end
        vectors++; if (seen !== 1) begin miscompares++; $display("FAIL midtx_latch_seen got %0d want 1", seen); end
        #1 sys_rst_l = 1'b0;
        #1;
        vectors++; if (tx_latch !== 1'b0) begin miscompares++; $display("FAIL midtx_latch got %b want 0", tx_latch); end
        vectors++; if (ch_out !== '0) begin miscompares++; $display("FAIL midtx_ch_out got %h want 0", ch_out); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL midtx_tx_data got %h want 00", tx_data); end
        apply_reset();
    endtask

    task automatic test_random();
        int mark = cap_q.size();
        int fe0  = fe_count;
        int ack0 = exp_ack;
        int efe0 = exp_fe;
        logic [7:0] a, d, c, nz;
        do sw = 8'($urandom_range(0, 255)); while (sw == 8'h06);
        for (int p = 0; p < 20; p++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                do nz = 8'($urandom_range(0, 255)); while (nz == 8'hA5);
                drive_byte(nz);
            end
            case ($urandom_range(0, 4))
                0: a = 8'h00;
                1: a = 8'h01;
                2: a = 8'h02;
                3: a = 8'hFF;
                default: a = 8'($urandom_range(0, 255));
            endcase
            d = 8'($urandom_range(0, 255));
            c = ($urandom_range(0, 3) != 0) ? (a ^ d ^ 8'hA5) : 8'($urandom_range(0, 255));
            send_pkt(8'hA5, a, d, c, $urandom_range(0, 2));
            model_packet(a, d, c);
            idle(70);
            vectors++; if (ch_out !== exp_ch()) begin miscompares++; $display("FAIL rand%0d_ch_out got %h want %h", p, ch_out, exp_ch()); end
            vectors++; if (leds !== m_leds) begin miscompares++; $display("FAIL rand%0d_leds got %h want %h", p, leds, m_leds); end
            vectors++; if (fe_count - fe0 !== exp_fe - efe0) begin miscompares++; $display("FAIL rand%0d_ferr got %0d want %0d", p, fe_count - fe0, exp_fe - efe0); end
        end
        vectors++; if (count_byte(8'h06, mark) !== exp_ack - ack0) begin miscompares++; $display("FAIL rand_ack got %0d want %0d", count_byte(8'h06, mark), exp_ack - ack0); end
        sw = 8'h3C;
    endtask

    initial begin
        test_reset();
        test_single();
        test_broadcast();
        test_errors();
        test_timeout();
        test_status();
        test_collision();
        test_reset_mid();
        test_random();
        vectors++; if (viol !== 0) begin miscompares++; $display("FAIL protocol_violations got %0d want 0", viol); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/beat_link.md
# beat_link

Parametrised UART link controller between the byte-level `uart` core and the light-box outputs. It parses framed, checksummed command packets from the receive byte stream into `NUM_CH` channel registers, with broadcast, error detection and inter-byte timeout. It also schedules ACK and periodic switch-status bytes onto the transmitter through a proper latch/done handshake. It replaces direct byte-to-box wiring in the top level.

## Interface
- `NUM_CH`, 3: number of box channels (1..254).
- `CH_W`, 4: bits per channel (1..8).
- `STAT_PERIOD`, 1000000: sys_clk cycles between status transmissions (≥ 2).
- `TIMEOUT`, 50000: max sys_clk cycles between bytes of one packet (≥ 2).

Ports:
- `sys_clk` in 1: system clock; all logic on rising edge.
- `sys_rst_l` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: single-cycle strobe; `rx_data` valid.
- `rx_data` in 8: received byte.
- `tx_done` in 1: high while the transmitter is idle.
- `tx_latch` out 1: single-cycle request to send `tx_data`.
- `tx_data` out 8: byte to send; stable from latch until `tx_done` returns high.
- `sw` in 8: switch value reported in status bytes.
- `ch_out` out NUM_CH*CH_W: channel i occupies bits [i*CH_W +: CH_W].
- `leds` out 8: DATA byte of the last accepted packet.
- `frame_err` out 1: single-cycle pulse on any rejected/aborted packet.

## Operation
- Packet: SYNC (0xA5), ADDR, DATA, CHK, where CHK = ADDR ^ DATA ^ 0xA5.
- RX FSM states: R_SYNC, R_ADDR, R_DATA, R_CHK.
  - R_SYNC: a byte of 0xA5 moves to R_ADDR. Any other byte is ignored silently.
  - R_ADDR: latch ADDR and move to R_DATA.
  - R_DATA: latch DATA and move to R_CHK.
  - R_CHK: return to R_SYNC. If the checksum matches and (ADDR < NUM_CH or ADDR == 0xFF), commit the packet; otherwise pulse `frame_err`.
- Commit: `ch_out[ADDR]` ← DATA[CH_W-1:0]. ADDR 0xFF writes every channel. `leds` ← DATA. Set `ack_pend`.
- Timeout: in any state other than R_SYNC, a gap counter counts cycles without `rx_valid`. When it reaches TIMEOUT, go to R_SYNC and pulse `frame_err`. The counter clears on each `rx_valid`.
- Status timer: free-running counter from 0 to STAT_PERIOD-1. At wrap it sets `stat_pend`.
- TX arbiter: ACK byte 0x06 has priority over status byte `sw`. `sw` is sampled at latch time.
- TX FSM states: T_IDLE, T_LATCH, T_BUSY, T_DONE.
  - T_IDLE: when a pending flag is set and `tx_done`=1, load `tx_data`, clear the chosen flag and go to T_LATCH.
  - T_LATCH: `tx_latch`=1 for this cycle only, then go to T_BUSY.
  - T_BUSY: wait for `tx_done`=0, then go to T_DONE.
  - T_DONE: wait for `tx_done`=1, then go to T_IDLE.
- Pending flags saturate: multiple events while busy collapse to one byte of each type.

## Timing
- Reset values: `ch_out`=0, `leds`=0, `tx_latch`=0, `tx_data`=0, `frame_err`=0, RX FSM=R_SYNC, TX FSM=T_IDLE, all counters and pending flags = 0.
- Commit is registered. `ch_out`/`leds` update in the cycle after the CHK byte's `rx_valid`, and `frame_err` pulses in that same cycle.
- Back-to-back `rx_valid` on consecutive cycles must be accepted.
- Earliest `tx_latch`: 2 cycles after the pending flag is set, provided `tx_done` is high.
- Simultaneous status wrap and commit: both flags set. ACK is sent first, status next.
- Timeout and `rx_valid` in the same cycle: the byte wins and no timeout occurs.
- Reset mid-packet or mid-transmit: everything returns to reset values immediately. `tx_latch` is forced low asynchronously.

## Structure
- `beat_link_pkg`: SYNC_BYTE, ACK_BYTE, BCAST_ADDR constants; `rx_state_t` and `tx_state_t` enums.
- One sub-module, `beat_link_tx`, containing the TX FSM, arbiter and pending flags. Its inputs are `ack_req`/`stat_req` pulses plus `sw`, `tx_done`. Its outputs are `tx_latch`/`tx_data`.

## Test plan
- Reset, then packet A5 01 0B AF (CHK = 01^0B^A5) → `ch_out`=0x0B0, `leds`=0x0B, and one `tx_latch` with `tx_data`=0x06.
- Broadcast A5 FF 07 5D → all channels = 7 (`ch_out`=0x777), ACK sent, no `frame_err`.
- Bad checksum A5 01 0B 00, then bad address A5 05 01 A1 → two `frame_err` pulses, `ch_out` unchanged, no ACK.
- A5 02 then silence for TIMEOUT cycles → `frame_err` at the timeout. A following valid packet to ch2 commits.
- `sw`=0x3C, no RX traffic, `tx_done` model busy for 100 cycles per byte → exactly one latch per STAT_PERIOD with `tx_data`=0x3C. Latch never issued while `tx_done`=0.
- Commit landing in the same cycle as status wrap → ACK byte first, status byte second, each `tx_latch` exactly one cycle.
